// File: rtl/instr_fetch_queue.sv
// Instruction fetch FSM feeding a circular queue of {instr, pc+4} entries for decode.
// Latency: an acked word is visible at the head the cycle after imem_ack (no bypass).
// Backpressure: o_if_valid/i_stall on the decode side; no request is issued while the queue is full.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_imem_req,
  output logic [31:0]              o_imem_addr,
  input  logic                     i_imem_ack,
  input  logic [31:0]              i_imem_rdata,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  input  logic                     i_stall,
  output logic                     o_if_valid,
  output logic [31:0]              o_if_instr,
  output logic [31:0]              o_if_pc4,
  output logic [$clog2(DEPTH):0]   o_q_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP  = 32'hFC00_0000;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fpc, w_fpc_nxt;
  logic [31:0]     r_imem_addr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [31:0]     r_q_instr [DEPTH];
  logic [31:0]     r_q_pc4   [DEPTH];

  logic            w_push, w_pop;
  logic [CW-1:0]   w_cnt_pp;   // occupancy after this cycle's pop, before any push

  // Next-state, fetch PC and push/pop decisions; redirect overrides push and pop.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_push      = 1'b0;
    w_pop       = (r_count != '0) && !i_stall && !i_redirect;
    w_cnt_pp    = r_count - CW'(w_pop);
    case (r_state)
      IDLE: begin
        if (i_redirect) begin
          w_fpc_nxt = i_redirect_pc;
        end else if (w_cnt_pp < FULL) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          w_fpc_nxt   = i_redirect_pc;
          w_state_nxt = i_imem_ack ? IDLE : DROP;
        end else if (i_imem_ack) begin
          w_push      = 1'b1;
          w_fpc_nxt   = r_fpc + 32'd4;
          w_state_nxt = ((w_cnt_pp + CW'(1)) < FULL) ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (i_redirect) w_fpc_nxt = i_redirect_pc;
        if (i_imem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, fetch PC and request address; the address is frozen while a request is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_fpc       <= RESET_PC;
      r_imem_addr <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      if (r_state == IDLE || i_imem_ack) r_imem_addr <= w_fpc_nxt;
    end
  end

  // Queue pointers and occupancy; redirect flushes everything back to slot 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (i_redirect) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage; contents are only observed through the valid-gated head mux.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= i_imem_rdata;
      r_q_pc4[r_wptr]   <= w_fpc_nxt;
    end
  end

  assign o_imem_req  = (r_state != IDLE);
  assign o_imem_addr = r_imem_addr;
  assign o_q_count   = r_count;
  assign o_if_valid  = (r_count != '0);
  assign o_if_instr  = o_if_valid ? r_q_instr[r_rptr] : NOP;
  assign o_if_pc4    = o_if_valid ? r_q_pc4[r_rptr]   : 32'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: table of per-cycle stimulus with outputs expected after the edge.
// Hand sequences cover asynchronous reset mid-request and the first fetch after release.
// Outputs are sampled 1 time unit after the rising edge.
module tb_instr_fetch_queue;

  localparam logic [31:0] NOP = 32'hFC00_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [2:0]  q_count;

  int checks   = 0;
  int failures = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_stall       (stall),
    .o_if_valid    (if_valid),
    .o_if_instr    (if_instr),
    .o_if_pc4      (if_pc4),
    .o_q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic a, input logic [31:0] d, input logic rd,
                     input logic [31:0] rp, input logic s, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep, input logic [7:0] ec);
    vec_t v;
    v.rst_n = r; v.ack = a; v.rdata = d; v.redir = rd; v.rpc = rp; v.stall = s;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_pc4 = ep; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [31:0] ea, input logic ev,
                         input logic [31:0] ei, input logic [31:0] ep, input logic [7:0] ec);
    chk({tag, ".req"},   32'(imem_req),  32'(er));
    chk({tag, ".addr"},  imem_addr,      ea);
    chk({tag, ".valid"}, 32'(if_valid),  32'(ev));
    chk({tag, ".instr"}, if_instr,       ei);
    chk({tag, ".pc4"},   if_pc4,         ep);
    chk({tag, ".count"}, 32'(q_count),   32'(ec));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seen;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;

    //   rst ack rdata          rdr rpc            stl | req addr           vld instr          pc4            cnt
    // streaming with acks one cycle after each request
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0000, 0, NOP,           32'h0,         0);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0000, 0, NOP,           32'h0,         0);
    add(1, 1, 32'hA000_0000,  0, 32'h0,          0,   1, 32'h0000_0004, 1, 32'hA000_0000, 32'h4,         1);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0004, 0, NOP,           32'h0,         0);
    add(1, 1, 32'hA000_0004,  0, 32'h0,          0,   1, 32'h0000_0008, 1, 32'hA000_0004, 32'h8,         1);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0008, 0, NOP,           32'h0,         0);
    add(1, 1, 32'hA000_0008,  0, 32'h0,          0,   1, 32'h0000_000C, 1, 32'hA000_0008, 32'hC,         1);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_000C, 0, NOP,           32'h0,         0);
    // stall held, immediate acks: fill to four then stop requesting
    add(1, 1, 32'hA000_000C,  0, 32'h0,          1,   1, 32'h0000_0010, 1, 32'hA000_000C, 32'h10,        1);
    add(1, 1, 32'hA000_0010,  0, 32'h0,          1,   1, 32'h0000_0014, 1, 32'hA000_000C, 32'h10,        2);
    add(1, 1, 32'hA000_0014,  0, 32'h0,          1,   1, 32'h0000_0018, 1, 32'hA000_000C, 32'h10,        3);
    add(1, 1, 32'hA000_0018,  0, 32'h0,          1,   0, 32'h0000_001C, 1, 32'hA000_000C, 32'h10,        4);
    add(1, 1, 32'hDEAD_BEEF,  0, 32'h0,          1,   0, 32'h0000_001C, 1, 32'hA000_000C, 32'h10,        4);
    // one pop opens exactly one slot and one request
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_001C, 1, 32'hA000_0010, 32'h14,        3);
    add(1, 0, 32'h0,          0, 32'h0,          1,   1, 32'h0000_001C, 1, 32'hA000_0010, 32'h14,        3);
    add(1, 1, 32'hA000_001C,  0, 32'h0,          1,   0, 32'h0000_0020, 1, 32'hA000_0010, 32'h14,        4);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0020, 1, 32'hA000_0014, 32'h18,        3);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0020, 1, 32'hA000_0018, 32'h1C,        2);
    // redirect coincident with ack and pop at count 2
    add(1, 1, 32'hBAD0_0000,  1, 32'h0000_0200,  0,   0, 32'h0000_0200, 0, NOP,           32'h0,         0);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0200, 0, NOP,           32'h0,         0);
    // reset while a request is outstanding, stray ack after release
    add(0, 0, 32'h0,          0, 32'h0,          0,   0, RPC,           0, NOP,           32'h0,         0);
    add(1, 1, 32'hDEAD_BEEF,  0, 32'h0,          0,   1, RPC,           0, NOP,           32'h0,         0);
    add(1, 1, 32'hA000_0000,  0, 32'h0,          0,   1, 32'h0000_0004, 1, 32'hA000_0000, 32'h4,         1);
    add(1, 1, 32'hA000_0004,  0, 32'h0,          0,   1, 32'h0000_0008, 1, 32'hA000_0004, 32'h8,         1);
    // redirect to 0x100 while 0x8 is outstanding; ack arrives three cycles later and is dropped
    add(1, 0, 32'h0,          1, 32'h0000_0100,  0,   1, 32'h0000_0008, 0, NOP,           32'h0,         0);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0008, 0, NOP,           32'h0,         0);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0008, 0, NOP,           32'h0,         0);
    add(1, 1, 32'hA000_0008,  0, 32'h0,          0,   0, 32'h0000_0100, 0, NOP,           32'h0,         0);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0100, 0, NOP,           32'h0,         0);
    add(1, 1, 32'hA000_0100,  0, 32'h0,          1,   1, 32'h0000_0104, 1, 32'hA000_0100, 32'h104,       1);
    // redirect into DROP, second redirect in DROP retargets, then address wrap
    add(1, 0, 32'h0,          1, 32'h0000_0300,  0,   1, 32'h0000_0104, 0, NOP,           32'h0,         0);
    add(1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0,   1, 32'h0000_0104, 0, NOP,           32'h0,         0);
    add(1, 1, 32'hBAD0_0104,  0, 32'h0,          0,   0, 32'hFFFF_FFFC, 0, NOP,           32'h0,         0);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'hFFFF_FFFC, 0, NOP,           32'h0,         0);
    add(1, 1, 32'hA0FF_FFFC,  0, 32'h0,          1,   1, 32'h0000_0000, 1, 32'hA0FF_FFFC, 32'h0,         1);
    add(1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0000_0000, 0, NOP,           32'h0,         0);

    // reset values while reset is held
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset", 1'b0, RPC, 1'b0, NOP, 32'h0, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n       = vecs[i].rst_n;
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].rdata;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      stall       = vecs[i].stall;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
              vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_cnt);
    end

    // push one entry so reset has something to clear, then reset asynchronously mid-cycle
    imem_ack = 1'b1; imem_rdata = 32'h5555_0000; redirect = 1'b0; stall = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset.count", 32'(q_count), 32'd1);
    chk("pre_reset.addr", imem_addr, 32'h0000_0004);
    imem_ack = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_all("async_reset", 1'b0, RPC, 1'b0, NOP, 32'h0, 8'd0);

    // release, stray ack in the first cycle; the first request must target RESET_PC
    @(posedge clk); #1;
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      if (imem_req) seen = 1'b1;
    end
    chk("first_req.seen", 32'(seen), 32'd1);
    chk("first_req.addr", imem_addr, RPC);
    chk("first_req.instr", if_instr, NOP);
    chk("first_req.count", 32'(q_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
